set_mode_ctrl: RTL and testbench
================================

# set_mode_ctrl

Button-driven set-mode sequencer for the clock/calendar datapath. It walks the user through hour, minute, day, month and year fields, applying increment and decrement with wrap and calendar-correct day limits. It then commits the edited values to the clock and calendar in one load. It sits between the debounced push-buttons and the `time_set`/`date_ow` overwrite inputs of the clock and calendar. It replaces direct switch control of the overwrite words.

## Interface
Parameters:
- `REPEAT_DELAY`, 50_000_000: cycles a held up/down button must stay high before auto-repeat starts.
- `REPEAT_RATE`, 10_000_000: cycles between auto-repeat steps once repeating.
- `TIMEOUT_CYCLES`, 1_000_000_000: idle cycles before set mode is abandoned. Used only with the timeout feature.

Ports:
- `clk_100MHz` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `btn_mode` in 1: center button; level, already synchronized and debounced.
- `btn_up` in 1: up button; level, synchronized and debounced.
- `btn_down` in 1: down button; level, synchronized and debounced.
- `cur_hour` in 5: live hour (0–23), sampled on entry.
- `cur_min` in 6: live minute (0–59), sampled on entry.
- `cur_day` in 5: live day (1–31), sampled on entry.
- `cur_month` in 4: live month (1–12), sampled on entry.
- `cur_year` in 12: live year (0–4095), sampled on entry.
- `set_active` out 1: drives clock `time_set` and calendar `date_ow`.
- `load` out 1: one-cycle commit strobe.
- `time_word` out 17: `{hour[4:0], min[5:0], sec[5:0]}`; sec is always 0.
- `date_word` out 21: `{day[4:0], month[3:0], year[11:0]}`.
- `field` out 3: field being edited; 0 = none, 1 = hour, 2 = min, 3 = day, 4 = month, 5 = year. Used for display blinking.

## Operation
- States: IDLE, HOUR, MIN, DAY, MONTH, YEAR, COMMIT.
- IDLE → HOUR on a `btn_mode` rising edge. The same edge loads all five edit registers from the `cur_*` inputs.
- Each `btn_mode` edge advances HOUR→MIN→DAY→MONTH→YEAR→COMMIT.
- COMMIT lasts 1 cycle, then returns to IDLE.
- `set_active` is 1 in every state except IDLE.
- `load` is 1 only in COMMIT.
- `time_word` and `date_word` always reflect the edit registers.
- `field` reports the current state's code; it is 0 in IDLE and in COMMIT.
- An up/down step changes only the current field's register:
  - hour wraps 23↔0;
  - min wraps 59↔0;
  - month wraps 12↔1;
  - year wraps 4095↔0;
  - day wraps max_day↔1.
- max_day follows the Gregorian rule: 31/30 by month; Feb = 29 if (y%4==0 && y%100!=0) || y%400==0, else 28.
- Whenever month or year changes, day is clamped to the new max_day in the same cycle. Example: 31 → 30 when the month becomes April.
- Step generation, per button:
  - a rising edge gives 1 step;
  - if the button is still held REPEAT_DELAY cycles after that edge, 1 step;
  - then 1 step every REPEAT_RATE cycles while it stays held;
  - release resets the repeat counter.
- Simultaneous events:
  - up and down both high: no step, and both repeat counters are held at 0;
  - `btn_mode` edge in the same cycle as a step: the mode edge wins and the step is discarded.
- Up/down in IDLE are ignored.

## Timing
- Reset values: state IDLE, `set_active`=0, `load`=0, `field`=0, edit registers hour=0 min=0 day=1 month=1 year=0.
- Reset mid-operation returns to IDLE immediately. No `load` is issued.
- Edge detection is registered, so an input rise at cycle N produces its effect at cycle N+1:
  - `btn_mode` rise at N: state and `field` change at N+1.
  - up/down rise at N: edit register updated at N+1.
  - Auto-repeat steps land at N+1+REPEAT_DELAY, then every REPEAT_RATE cycles.
- YEAR mode edge at N: COMMIT at N+1 (`load`=1, `set_active`=1), IDLE at N+2 (`set_active`=0).
- The datapath captures the words on `load`.
- `cur_*` are sampled only on the IDLE→HOUR edge; later changes are ignored.

## Configuration
- `SET_CTRL_TIMEOUT_EN` defined:
  - a counter counts cycles with no button activity while not IDLE;
  - reaching TIMEOUT_CYCLES forces IDLE without COMMIT, so `load` never pulses;
  - any button level high restarts the counter.
- Undefined: no timeout logic; set mode persists until COMMIT or `reset`.

## Structure
- Shared package `clk_cal_pkg` holds:
  - the state enum;
  - the field codes 0–5;
  - widths HR_W=5, MIN_W=6, DAY_W=5, MON_W=4, YR_W=12;
  - the `days_in_month(month, year)` function.
- One sub-module `btn_repeat` does edge detection plus auto-repeat and outputs a single-cycle `step` pulse. It is instantiated twice, once for up and once for down. The mode button uses plain edge detection.

## Test plan
- Entry with cur 13:45 on 15/06/2024, mode press → `field`=1, `set_active`=1; then up ×11 → hour wraps to 0.
- In DAY with day=1, down → day=31 in January. Set day=31 and month=1, go to MONTH, up → month=2, day=29 for year 2024; repeat with year 1900 → day=28.
- In YEAR with year=2000 Feb 29, down → year=1999, day=28. In YEAR with year=4095, up → year=0.
- Hold up for REPEAT_DELAY+3×REPEAT_RATE+1 cycles in MIN from 10 → min=15.
- Full walk to COMMIT → `load` high for exactly 1 cycle; `time_word`={hour,min,6'd0}; `set_active` drops the next cycle. Then assert `reset` during MONTH → IDLE with no `load`.
- With `SET_CTRL_TIMEOUT_EN` and TIMEOUT_CYCLES=100, enter HOUR and stay idle 100 cycles → IDLE with no `load`. Up and down held together → no value change.

Source files
------------

// File: rtl/clk_cal_pkg.sv
// clk_cal_pkg: states, field codes, widths and the calendar
// day-limit helper shared by the set-mode controller.
package clk_cal_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int DAY_W = 5;
  localparam int MON_W = 4;
  localparam int YR_W  = 12;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOUR   = 3'd1,
    S_MIN    = 3'd2,
    S_DAY    = 3'd3,
    S_MONTH  = 3'd4,
    S_YEAR   = 3'd5,
    S_COMMIT = 3'd6
  } state_t;

  localparam logic [2:0] F_NONE  = 3'd0;
  localparam logic [2:0] F_HOUR  = 3'd1;
  localparam logic [2:0] F_MIN   = 3'd2;
  localparam logic [2:0] F_DAY   = 3'd3;
  localparam logic [2:0] F_MONTH = 3'd4;
  localparam logic [2:0] F_YEAR  = 3'd5;

  function automatic logic [DAY_W-1:0] days_in_month(
    input logic [MON_W-1:0] month,
    input logic [YR_W-1:0]  year
  );
    logic leap;
    leap = ((year[1:0] == 2'd0) && ((year % 12'd100) != 12'd0))
        || ((year % 12'd400) == 12'd0);
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:    days_in_month = leap ? 5'd29 : 5'd28;
      default: days_in_month = 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: rising-edge step plus hold-to-repeat for one
// debounced button; hold suppresses steps and clears the counter.
module btn_repeat #(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic hold,
  output logic step
);

  logic        btn_q;
  logic        rep;
  logic [31:0] cnt;
  logic [31:0] limit;
  logic        rise;
  logic        at_limit;

  assign rise     = btn & ~btn_q;
  assign limit    = rep ? REPEAT_RATE : REPEAT_DELAY;
  assign at_limit = btn && (cnt == limit);
  assign step     = !hold && (rise || at_limit);

  // cnt holds cycles elapsed since the edge or since the last repeat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q <= 1'b0;
      rep   <= 1'b0;
      cnt   <= '0;
    end else begin
      btn_q <= btn;
      if (hold || !btn) begin
        rep <= 1'b0;
        cnt <= '0;
      end else if (rise) begin
        rep <= 1'b0;
        cnt <= 32'd1;
      end else if (at_limit) begin
        rep <= 1'b1;
        cnt <= 32'd1;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/set_mode_ctrl.sv
// set_mode_ctrl: button-driven hour/min/day/month/year editor.
// Optional idle abandon via SET_CTRL_TIMEOUT_EN.
module set_mode_ctrl
  import clk_cal_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY   = 50_000_000,
  parameter int unsigned REPEAT_RATE    = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [HR_W-1:0]   cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [DAY_W-1:0]  cur_day,
  input  logic [MON_W-1:0]  cur_month,
  input  logic [YR_W-1:0]   cur_year,
  output logic              set_active,
  output logic              load,
  output logic [16:0]       time_word,
  output logic [20:0]       date_word,
  output logic [2:0]        field
);

  state_t state, state_d;
  logic [HR_W-1:0]  hour, hour_d;
  logic [MIN_W-1:0] minute, minute_d;
  logic [DAY_W-1:0] day, day_d;
  logic [MON_W-1:0] month, month_d;
  logic [YR_W-1:0]  year, year_d;
  logic [DAY_W-1:0] max_cur, max_new;

  logic mode_q, mode_rise;
  logic both, up_step, dn_step, inc, dec;
  logic timeout;

  assign mode_rise = btn_mode & ~mode_q;
  assign both      = btn_up & btn_down;
  assign inc       = up_step & ~mode_rise;
  assign dec       = dn_step & ~mode_rise;
  assign max_cur   = days_in_month(month, year);

  btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_up (
    .clk  (clk_100MHz),
    .reset(reset),
    .btn  (btn_up),
    .hold (both),
    .step (up_step)
  );

  btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_dn (
    .clk  (clk_100MHz),
    .reset(reset),
    .btn  (btn_down),
    .hold (both),
    .step (dn_step)
  );

`ifdef SET_CTRL_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        any_btn;

  assign any_btn = btn_mode | btn_up | btn_down;
  assign timeout = (state != S_IDLE) && !any_btn
                && (idle_cnt == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)
      idle_cnt <= '0;
    else if (state == S_IDLE || any_btn)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 32'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      mode_q <= 1'b0;
      hour   <= '0;
      minute <= '0;
      day    <= 5'd1;
      month  <= 4'd1;
      year   <= '0;
    end else begin
      state  <= state_d;
      mode_q <= btn_mode;
      hour   <= hour_d;
      minute <= minute_d;
      day    <= day_d;
      month  <= month_d;
      year   <= year_d;
    end
  end

  always_comb begin
    state_d  = state;
    hour_d   = hour;
    minute_d = minute;
    day_d    = day;
    month_d  = month;
    year_d   = year;
    case (state)
      S_IDLE: if (mode_rise) begin
        state_d  = S_HOUR;
        hour_d   = cur_hour;
        minute_d = cur_min;
        day_d    = cur_day;
        month_d  = cur_month;
        year_d   = cur_year;
      end
      S_HOUR: begin
        if (mode_rise) state_d = S_MIN;
        else if (inc) hour_d = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
        else if (dec) hour_d = (hour == 5'd0) ? 5'd23 : hour - 5'd1;
      end
      S_MIN: begin
        if (mode_rise) state_d = S_DAY;
        else if (inc) minute_d = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
        else if (dec) minute_d = (minute == 6'd0) ? 6'd59 : minute - 6'd1;
      end
      S_DAY: begin
        if (mode_rise) state_d = S_MONTH;
        else if (inc) day_d = (day >= max_cur) ? 5'd1 : day + 5'd1;
        else if (dec) day_d = (day <= 5'd1) ? max_cur : day - 5'd1;
      end
      S_MONTH: begin
        if (mode_rise) state_d = S_YEAR;
        else if (inc) month_d = (month >= 4'd12) ? 4'd1 : month + 4'd1;
        else if (dec) month_d = (month <= 4'd1) ? 4'd12 : month - 4'd1;
      end
      S_YEAR: begin
        if (mode_rise) state_d = S_COMMIT;
        else if (inc) year_d = year + 12'd1;
        else if (dec) year_d = year - 12'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // keep day legal for whatever month/year will be registered
    if (day_d > max_new) day_d = max_new;
    if (timeout) state_d = S_IDLE;
  end

  assign max_new = days_in_month(month_d, year_d);

  always_comb begin
    set_active = (state != S_IDLE);
    load       = (state == S_COMMIT);
    case (state)
      S_HOUR:  field = F_HOUR;
      S_MIN:   field = F_MIN;
      S_DAY:   field = F_DAY;
      S_MONTH: field = F_MONTH;
      S_YEAR:  field = F_YEAR;
      default: field = F_NONE;
    endcase
  end

  assign time_word = {hour, minute, 6'd0};
  assign date_word = {day, month, year};

endmodule

// File: tb/tb_set_mode_ctrl.sv
// tb_set_mode_ctrl: directed checks of set_mode_ctrl with short
// repeat/timeout parameters.
module tb_set_mode_ctrl;

  localparam int unsigned RD = 20;
  localparam int unsigned RR = 5;
  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic [4:0]  cur_hour = '0;
  logic [5:0]  cur_min = '0;
  logic [4:0]  cur_day = 5'd1;
  logic [3:0]  cur_month = 4'd1;
  logic [11:0] cur_year = '0;
  logic        set_active;
  logic        load;
  logic [16:0] time_word;
  logic [20:0] date_word;
  logic [2:0]  field;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  set_mode_ctrl #(
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_100MHz(clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .cur_hour  (cur_hour),
    .cur_min   (cur_min),
    .cur_day   (cur_day),
    .cur_month (cur_month),
    .cur_year  (cur_year),
    .set_active(set_active),
    .load      (load),
    .time_word (time_word),
    .date_word (date_word),
    .field     (field)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    btn_mode = 0; btn_up = 0; btn_down = 0;
    reset = 1;
    tick(2);
    reset = 0;
    tick(1);
  endtask

  task automatic press_mode(input int n = 1);
    repeat (n) begin
      btn_mode = 1; tick(1);
      btn_mode = 0; tick(1);
    end
  endtask

  task automatic press_up(input int n = 1);
    repeat (n) begin
      btn_up = 1; tick(1);
      btn_up = 0; tick(1);
    end
  endtask

  task automatic press_down();
    btn_down = 1; tick(1);
    btn_down = 0; tick(1);
  endtask

  task automatic set_cur(input int h, input int m, input int d,
                         input int mo, input int y);
    cur_hour = 5'(h); cur_min = 6'(m); cur_day = 5'(d);
    cur_month = 4'(mo); cur_year = 12'(y);
  endtask

  task automatic test_reset();
    reset = 1;
    tick(2);
    total++;
    if (set_active !== 1'b0 || load !== 1'b0 || field !== 3'd0) begin
      bad++;
      $display("FAIL reset_ctrl: act=%b load=%b field=%0d want 0 0 0",
               set_active, load, field);
    end
    total++;
    if (time_word !== 17'd0 || date_word !== {5'd1, 4'd1, 12'd0}) begin
      bad++;
      $display("FAIL reset_words: time=%h date=%h want 0 and %h",
               time_word, date_word, {5'd1, 4'd1, 12'd0});
    end
    reset = 0;
    tick(1);
  endtask

  task automatic test_entry_hour_wrap();
    do_reset();
    set_cur(13, 45, 15, 6, 2024);
    press_mode();
    total++;
    if (field !== 3'd1 || set_active !== 1'b1) begin
      bad++;
      $display("FAIL entry: field=%0d act=%b want 1 1", field, set_active);
    end
    total++;
    if (time_word !== {5'd13, 6'd45, 6'd0} ||
        date_word !== {5'd15, 4'd6, 12'd2024}) begin
      bad++;
      $display("FAIL entry_sample: time=%h date=%h", time_word, date_word);
    end
    set_cur(2, 3, 4, 5, 6);
    press_up(10);
    total++;
    if (time_word[16:12] !== 5'd23) begin
      bad++;
      $display("FAIL hour_23: got %0d want 23", time_word[16:12]);
    end
    press_up(1);
    total++;
    if (time_word[16:12] !== 5'd0 || time_word[11:6] !== 6'd45) begin
      bad++;
      $display("FAIL hour_wrap: got %0d:%0d want 0:45",
               time_word[16:12], time_word[11:6]);
    end
  endtask

  task automatic test_day_month(input int y, input int want_day);
    do_reset();
    set_cur(0, 0, 1, 1, y);
    press_mode(3);
    total++;
    if (field !== 3'd3) begin
      bad++;
      $display("FAIL day_field: got %0d want 3", field);
    end
    press_down();
    total++;
    if (date_word[20:16] !== 5'd31) begin
      bad++;
      $display("FAIL day_wrap y%0d: got %0d want 31", y, date_word[20:16]);
    end
    press_mode();
    press_up();
    total++;
    if (date_word !== {5'(want_day), 4'd2, 12'(y)}) begin
      bad++;
      $display("FAIL feb_clamp y%0d: day=%0d mon=%0d want %0d 2", y,
               date_word[20:16], date_word[15:12], want_day);
    end
  endtask

  task automatic test_year();
    do_reset();
    set_cur(0, 0, 29, 2, 2000);
    press_mode(5);
    press_down();
    total++;
    if (date_word !== {5'd28, 4'd2, 12'd1999}) begin
      bad++;
      $display("FAIL year_dec: day=%0d year=%0d want 28 1999",
               date_word[20:16], date_word[11:0]);
    end
    do_reset();
    set_cur(0, 0, 10, 1, 4095);
    press_mode(5);
    total++;
    if (field !== 3'd5) begin
      bad++;
      $display("FAIL year_field: got %0d want 5", field);
    end
    press_up();
    total++;
    if (date_word[11:0] !== 12'd0) begin
      bad++;
      $display("FAIL year_wrap: got %0d want 0", date_word[11:0]);
    end
  endtask

  task automatic test_repeat();
    do_reset();
    set_cur(0, 10, 1, 1, 2020);
    press_mode(2);
    btn_up = 1;
    tick(RD);
    total++;
    if (time_word[11:6] !== 6'd11) begin
      bad++;
      $display("FAIL rep_before_delay: got %0d want 11", time_word[11:6]);
    end
    tick(1);
    total++;
    if (time_word[11:6] !== 6'd12) begin
      bad++;
      $display("FAIL rep_delay: got %0d want 12", time_word[11:6]);
    end
    tick(3 * RR);
    btn_up = 0;
    tick(2);
    total++;
    if (time_word[11:6] !== 6'd15) begin
      bad++;
      $display("FAIL rep_rate: got %0d want 15", time_word[11:6]);
    end
    btn_up = 1; btn_down = 1;
    tick(RD + 2 * RR);
    btn_up = 0; btn_down = 0;
    tick(2);
    total++;
    if (time_word[11:6] !== 6'd15) begin
      bad++;
      $display("FAIL both_held: got %0d want 15", time_word[11:6]);
    end
  endtask

  task automatic test_mode_wins();
    do_reset();
    set_cur(5, 7, 1, 1, 2020);
    press_mode();
    btn_mode = 1; btn_up = 1;
    tick(1);
    btn_mode = 0; btn_up = 0;
    tick(1);
    total++;
    if (field !== 3'd2 || time_word !== {5'd5, 6'd7, 6'd0}) begin
      bad++;
      $display("FAIL mode_wins: field=%0d time=%h want 2 %h",
               field, time_word, {5'd5, 6'd7, 6'd0});
    end
  endtask

  task automatic test_commit();
    do_reset();
    set_cur(8, 30, 10, 3, 2021);
    press_mode();
    press_up(2);
    press_mode();
    press_down();
    press_mode(3);
    total++;
    if (load !== 1'b0 || field !== 3'd5) begin
      bad++;
      $display("FAIL pre_commit: load=%b field=%0d want 0 5", load, field);
    end
    btn_mode = 1;
    tick(1);
    total++;
    if (load !== 1'b1 || set_active !== 1'b1 || field !== 3'd0) begin
      bad++;
      $display("FAIL commit: load=%b act=%b field=%0d want 1 1 0",
               load, set_active, field);
    end
    total++;
    if (time_word !== {5'd10, 6'd29, 6'd0} ||
        date_word !== {5'd10, 4'd3, 12'd2021}) begin
      bad++;
      $display("FAIL commit_words: time=%h date=%h", time_word, date_word);
    end
    btn_mode = 0;
    tick(1);
    total++;
    if (load !== 1'b0 || set_active !== 1'b0) begin
      bad++;
      $display("FAIL post_commit: load=%b act=%b want 0 0", load, set_active);
    end
  endtask

  task automatic test_reset_mid();
    int loads;
    do_reset();
    set_cur(1, 2, 3, 4, 2005);
    press_mode(4);
    total++;
    if (field !== 3'd4) begin
      bad++;
      $display("FAIL month_field: got %0d want 4", field);
    end
    loads = 0;
    reset = 1;
    #2;
    total++;
    if (set_active !== 1'b0 || field !== 3'd0) begin
      bad++;
      $display("FAIL async_reset: act=%b field=%0d want 0 0",
               set_active, field);
    end
    if (load) loads++;
    tick(1);
    reset = 0;
    repeat (4) begin
      if (load) loads++;
      tick(1);
    end
    total++;
    if (loads !== 0 || set_active !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_load: loads=%0d act=%b want 0 0",
               loads, set_active);
    end
  endtask

`ifdef SET_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int loads;
    do_reset();
    loads = 0;
    btn_mode = 1;
    tick(1);
    btn_mode = 0;
    repeat (TO - 1) begin
      if (load) loads++;
      tick(1);
    end
    total++;
    if (field !== 3'd1 || set_active !== 1'b1) begin
      bad++;
      $display("FAIL before_timeout: field=%0d act=%b want 1 1",
               field, set_active);
    end
    tick(1);
    total++;
    if (field !== 3'd0 || set_active !== 1'b0 || load !== 1'b0) begin
      bad++;
      $display("FAIL timeout: field=%0d act=%b load=%b want 0 0 0",
               field, set_active, load);
    end
    repeat (3) begin
      if (load) loads++;
      tick(1);
    end
    total++;
    if (loads !== 0) begin
      bad++;
      $display("FAIL timeout_no_load: loads=%0d want 0", loads);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_entry_hour_wrap();
    test_day_month(2024, 29);
    test_day_month(1900, 28);
    test_year();
    test_repeat();
    test_mode_wins();
    test_commit();
    test_reset_mid();
`ifdef SET_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
